pipeline_memp_stage8: RTL and testbench
=======================================

Name: pipeline_memp_stage8

Overview:
Memory-prepare stage of the 9-stage pipeline. It sits between the execute-side stage and the DRAM-read/writeback-prep stage (stage 9). It decodes the effective address into DRAM or system-bus space, builds byte masks and lane-aligned store data, and runs the DRAM request/acknowledge handshake. It stalls upstream while a DRAM request is outstanding and registers the pass-through control and data signals for stage 9 (`_MEMP` suffix).

Parameters:
- DRAM_BASE, 64'h0000_0000_8000_0000, first byte address of DRAM space.
- DRAM_SIZE, 64'h0000_0000_0800_0000, DRAM span in bytes. An address is in DRAM iff DRAM_BASE <= addr < DRAM_BASE+DRAM_SIZE; every other address is system bus.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  downstream stall; hold all `_MEMP` registers
- flush  in  1  squash the instruction being captured (insert bubble)
- valid_EX  in  1  upstream instruction valid
- pc_EX  in  64  instruction PC
- alu_result_EX  in  64  ALU result / effective address
- store_data_EX  in  64  rs2 value for stores
- mem_rd_EX  in  1  load
- mem_wr_EX  in  1  store
- mem_size_EX  in  2  00 byte, 01 half, 10 word, 11 dword
- rf_wr_sel_EX  in  2  writeback select, passed through
- rf_wr_en_EX  in  1  register write enable, passed through
- rd_EX  in  5  destination register
- dram_req  out  1  DRAM request
- dram_we  out  1  1 = write
- dram_addr  out  64  8-byte-aligned address (addr[2:0]=0)
- dram_wdata  out  64  lane-aligned store data
- dram_wmask  out  8  byte enables
- dram_ack  in  1  DRAM accepted request
- sys_bus_we  out  1  system-bus write strobe (one-cycle pulse)
- sys_bus_addr  out  64  system-bus address (full, unaligned)
- sys_bus_din  out  64  lane-aligned store data
- sys_bus_wmask  out  8  byte enables
- memp_busy  out  1  stall request to upstream stages
- is_dram_MEMP  out  1  access targets DRAM
- pc_MEMP  out  64
- rf_wr_sel_MEMP  out  2
- rf_wr_en_MEMP  out  1
- alu_result_MEMP  out  64
- rd_MEMP  out  5

Behaviour:
- Reset (reset==0, async): FSM to IDLE. Every output is 0, including dram_req, sys_bus_we and memp_busy.
- FSM states: IDLE and REQ.
- Capture condition: state==IDLE && !stall. On capture, all `_MEMP` registers load from `_EX` the next cycle (1-cycle latency). is_dram_MEMP = in-DRAM decode AND (mem_rd_EX|mem_wr_EX).
- If flush or !valid_EX at capture: bubble. rf_wr_en_MEMP=0, is_dram_MEMP=0, no request is issued; the other fields load normally.
- DRAM access captured: go to REQ. In the same edge, register dram_req=1, dram_we=mem_wr_EX, dram_addr, dram_wdata and dram_wmask.
- REQ: dram_req and its payload stay stable until dram_ack is sampled high. On that edge dram_req←0 and state←IDLE. Ack in the first REQ cycle is legal, giving 1 stall cycle minimum.
- memp_busy = (state==REQ) combinationally; upstream must hold its `_EX` inputs while it is high.
- stall while in REQ: the handshake still completes, but the FSM stays in IDLE afterwards without capturing until stall drops.
- flush while in REQ: the request is not cancelled (completes on ack). Flush only applies to the next capture.
- System-bus store captured: sys_bus_we pulses high for exactly one cycle with addr/din/wmask. No handshake and no busy.
- System-bus load: no strobe; sys_bus_addr is driven so stage 9 can sample sys_bus_dout.
- Non-memory instruction: pure pass-through. No strobes, is_dram_MEMP=0.
- Byte mask (a=addr[2:0]):
  - byte: 8'b1<<a
  - half: 8'b11<<{a[2:1],1'b0}
  - word: 8'hF<<{a[2],2'b0}
  - dword: 8'hFF
  - Loads use the same mask.
- Store data: the low 8/16/32/64 bits of store_data_EX, replicated across all lanes of the access width.
- dram_addr = {addr[63:3],3'b0}.

Optional Feature:
Macro MEMP_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_MEMP (1 bit, reset 0).
  - An access with addr not aligned to its size (half a[0]!=0, word a[1:0]!=0, dword a[2:0]!=0) is detected at capture. It issues no DRAM request and no sys_bus_we, and forces rf_wr_en_MEMP=0, is_dram_MEMP=0.
  - misalign_MEMP=1 for that instruction; misalign_MEMP is cleared on the next capture.
- Not defined: no port. Low address bits below the access size are ignored (access treated as aligned down) and no trap is raised.

Test Plan:
- Reset mid-REQ: drive reset=0 while dram_req=1 -> dram_req, memp_busy and all `_MEMP` outputs go to 0 immediately (async). After release, state is IDLE.
- DRAM word store at 0x8000_0004, data 0x1122_3344, size=10, ack after 3 cycles -> dram_wmask=8'hF0 and dram_wdata=64'h11223344_11223344, held stable 3 cycles. memp_busy is high 3 cycles; is_dram_MEMP=1 and rf_wr_en_MEMP=0.
- DRAM dword load at 0x8000_0010, ack in the first REQ cycle -> dram_we=0, dram_wmask=8'hFF, dram_addr=0x8000_0010. memp_busy is high exactly 1 cycle; rd_MEMP and rf_wr_en_MEMP are passed through.
- System-bus byte store at 0x1000_0003, data 0xAB -> sys_bus_we pulses 1 cycle with sys_bus_wmask=8'h08 and sys_bus_din=64'hABAB…AB. dram_req stays 0 and memp_busy stays 0.
- stall=1 held 4 cycles with a valid ALU instruction at the input -> `_MEMP` outputs unchanged for 4 cycles, then the instruction is captured on the first cycle with stall=0. flush=1 at capture -> rf_wr_en_MEMP=0.
- With MEMP_MISALIGN_TRAP_EN: half load at 0x8000_0001 -> no dram_req, misalign_MEMP=1, rf_wr_en_MEMP=0. Without the macro: dram_wmask=8'h03 and a request is issued.

Source files
------------

// File: rtl/pipeline_memp_stage8.sv
// ---------------------------------------------------------------------------
// pipeline_memp_stage8 -- memory-prepare stage (stage 8 of 9)
//
// Purpose:
//   This stage decodes the effective address into DRAM space or system-bus
//   space. It builds byte enables and lane-replicated store data, and runs
//   the DRAM request/acknowledge handshake. While a DRAM request is
//   outstanding it raises memp_busy to stall the upstream stages.
//   Pass-through control and data are registered for stage 9 (_MEMP).
//
// Optional feature (macro MEMP_MISALIGN_TRAP_EN):
//   When the macro is defined, a misaligned access raises misalign_MEMP.
//   That access issues no DRAM request and no bus strobe, and it does not
//   write a register. When the macro is undefined, the low address bits are
//   ignored and the access is treated as aligned down.
//
// Ports:
//   clk, reset (asynchronous, active-low)
//   stall, flush          : downstream hold / squash of the capture
//   *_EX                  : instruction fields from the execute stage
//   dram_*                : DRAM request channel (dram_ack is an input)
//   sys_bus_*             : system-bus strobe, address, data and mask
//   memp_busy             : upstream stall while a DRAM request is pending
//   *_MEMP                : registered fields for stage 9
//   misalign_MEMP         : misalignment trap flag (macro builds only)
// ---------------------------------------------------------------------------
module pipeline_memp_stage8 #(
   parameter logic [63:0] DRAM_BASE = 64'h0000_0000_8000_0000,
   parameter logic [63:0] DRAM_SIZE = 64'h0000_0000_0800_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        valid_EX,
   input  logic [63:0] pc_EX,
   input  logic [63:0] alu_result_EX,
   input  logic [63:0] store_data_EX,
   input  logic        mem_rd_EX,
   input  logic        mem_wr_EX,
   input  logic [1:0]  mem_size_EX,
   input  logic [1:0]  rf_wr_sel_EX,
   input  logic        rf_wr_en_EX,
   input  logic [4:0]  rd_EX,
   output logic        dram_req,
   output logic        dram_we,
   output logic [63:0] dram_addr,
   output logic [63:0] dram_wdata,
   output logic [7:0]  dram_wmask,
   input  logic        dram_ack,
   output logic        sys_bus_we,
   output logic [63:0] sys_bus_addr,
   output logic [63:0] sys_bus_din,
   output logic [7:0]  sys_bus_wmask,
   output logic        memp_busy,
   output logic        is_dram_MEMP,
   output logic [63:0] pc_MEMP,
   output logic [1:0]  rf_wr_sel_MEMP,
   output logic        rf_wr_en_MEMP,
   output logic [63:0] alu_result_MEMP,
`ifdef MEMP_MISALIGN_TRAP_EN
   output logic        misalign_MEMP,
`endif
   output logic [4:0]  rd_MEMP
);

   localparam logic [63:0] DRAM_END = DRAM_BASE + DRAM_SIZE;

   typedef enum logic {IDLE, REQ} state_t;
   state_t state_reg, state_next;

   logic [2:0]  a;
   logic        capture;
   logic        in_dram;
   logic        is_mem;
   logic        live;
   logic        misaligned;
   logic        mis_trap;
   logic        access_ok;
   logic        dram_go;
   logic        sys_access;
   logic        sys_store;
   logic [7:0]  mask_c;
   logic [63:0] lane_data;

   assign a         = alu_result_EX[2:0];
   assign capture   = (state_reg == IDLE) && !stall;
   assign in_dram   = (alu_result_EX >= DRAM_BASE) && (alu_result_EX < DRAM_END);
   assign is_mem    = mem_rd_EX | mem_wr_EX;
   assign live      = valid_EX & ~flush;

`ifdef MEMP_MISALIGN_TRAP_EN
   always_comb begin
      misaligned = 1'b0;
      case (mem_size_EX)
         2'b01:   misaligned = a[0];
         2'b10:   misaligned = |a[1:0];
         2'b11:   misaligned = |a;
         default: misaligned = 1'b0;
      endcase
   end
`else
   assign misaligned = 1'b0;
`endif

   assign mis_trap   = live & is_mem & misaligned;
   assign access_ok  = live & is_mem & ~misaligned;
   assign dram_go    = capture & access_ok & in_dram;
   assign sys_access = capture & access_ok & ~in_dram;
   assign sys_store  = sys_access & mem_wr_EX;

   // The byte enables select the lanes that the access covers. The shift
   // amounts drop the address bits below the access size, so the access is
   // aligned down.
   always_comb begin
      mask_c = 8'h00;
      case (mem_size_EX)
         2'b00: mask_c = 8'b0000_0001 << a;
         2'b01: mask_c = 8'b0000_0011 << {a[2:1], 1'b0};
         2'b10: mask_c = 8'b0000_1111 << {a[2], 2'b00};
         2'b11: mask_c = 8'hFF;
      endcase
   end

   // Each byte lane takes the store-data byte that sits at the same offset
   // within its naturally aligned container. This replicates the low
   // 8/16/32/64 bits across the full doubleword.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_lane
         always_comb begin
            lane_data[gi*8 +: 8] = store_data_EX[7:0];
            case (mem_size_EX)
               2'b00: lane_data[gi*8 +: 8] = store_data_EX[7:0];
               2'b01: lane_data[gi*8 +: 8] = store_data_EX[(gi % 2)*8 +: 8];
               2'b10: lane_data[gi*8 +: 8] = store_data_EX[(gi % 4)*8 +: 8];
               2'b11: lane_data[gi*8 +: 8] = store_data_EX[gi*8 +: 8];
            endcase
         end
      end
   endgenerate

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // FSM: next state and busy
   always_comb begin
      state_next = state_reg;
      memp_busy  = 1'b0;
      case (state_reg)
         IDLE: if (dram_go) state_next = REQ;
         REQ: begin
            memp_busy = 1'b1;
            if (dram_ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dram_req        <= 1'b0;
         dram_we         <= 1'b0;
         dram_addr       <= '0;
         dram_wdata      <= '0;
         dram_wmask      <= '0;
         sys_bus_we      <= 1'b0;
         sys_bus_addr    <= '0;
         sys_bus_din     <= '0;
         sys_bus_wmask   <= '0;
         is_dram_MEMP    <= 1'b0;
         pc_MEMP         <= '0;
         rf_wr_sel_MEMP  <= '0;
         rf_wr_en_MEMP   <= 1'b0;
         alu_result_MEMP <= '0;
         rd_MEMP         <= '0;
`ifdef MEMP_MISALIGN_TRAP_EN
         misalign_MEMP   <= 1'b0;
`endif
      end else begin
         // The strobe is asserted only in the cycle that follows a capture.
         sys_bus_we <= sys_store;

         if (capture) begin
            pc_MEMP         <= pc_EX;
            rf_wr_sel_MEMP  <= rf_wr_sel_EX;
            alu_result_MEMP <= alu_result_EX;
            rd_MEMP         <= rd_EX;
            rf_wr_en_MEMP   <= rf_wr_en_EX & live & ~mis_trap;
            is_dram_MEMP    <= access_ok & in_dram;
`ifdef MEMP_MISALIGN_TRAP_EN
            misalign_MEMP   <= mis_trap;
`endif
         end

         // The payload is written only when a request starts, so it stays
         // stable for the whole REQ period.
         if (dram_go) begin
            dram_req   <= 1'b1;
            dram_we    <= mem_wr_EX;
            dram_addr  <= {alu_result_EX[63:3], 3'b000};
            dram_wdata <= lane_data;
            dram_wmask <= mask_c;
         end else if (state_reg == REQ && dram_ack) begin
            dram_req   <= 1'b0;
         end

         if (sys_access) begin
            sys_bus_addr  <= alu_result_EX;
            sys_bus_din   <= lane_data;
            sys_bus_wmask <= mask_c;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_memp_stage8.sv
// ---------------------------------------------------------------------------
// tb_pipeline_memp_stage8 -- self-checking bench for pipeline_memp_stage8
//
// The bench applies a table of hand-derived vectors, then randomized
// instructions whose expected results come from a byte-level reference
// model. It also runs hand-written sequences for stall, flush, a stall that
// arrives during a request, and a reset asserted in the middle of a request.
// It honours MEMP_MISALIGN_TRAP_EN when that macro is defined.
// ---------------------------------------------------------------------------
module tb_pipeline_memp_stage8;

   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
   localparam logic [63:0] SIZE = 64'h0000_0000_0800_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, valid_EX = 1'b0;
   logic [63:0] pc_EX = '0, alu_result_EX = '0, store_data_EX = '0;
   logic        mem_rd_EX = 1'b0, mem_wr_EX = 1'b0;
   logic [1:0]  mem_size_EX = '0, rf_wr_sel_EX = '0;
   logic        rf_wr_en_EX = 1'b0;
   logic [4:0]  rd_EX = '0;
   logic        dram_req, dram_we, dram_ack = 1'b0;
   logic [63:0] dram_addr, dram_wdata;
   logic [7:0]  dram_wmask;
   logic        sys_bus_we;
   logic [63:0] sys_bus_addr, sys_bus_din;
   logic [7:0]  sys_bus_wmask;
   logic        memp_busy, is_dram_MEMP;
   logic [63:0] pc_MEMP, alu_result_MEMP;
   logic [1:0]  rf_wr_sel_MEMP;
   logic        rf_wr_en_MEMP;
   logic [4:0]  rd_MEMP;
`ifdef MEMP_MISALIGN_TRAP_EN
   logic        misalign_MEMP;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_memp_stage8 dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .valid_EX(valid_EX), .pc_EX(pc_EX), .alu_result_EX(alu_result_EX),
      .store_data_EX(store_data_EX), .mem_rd_EX(mem_rd_EX),
      .mem_wr_EX(mem_wr_EX), .mem_size_EX(mem_size_EX),
      .rf_wr_sel_EX(rf_wr_sel_EX), .rf_wr_en_EX(rf_wr_en_EX), .rd_EX(rd_EX),
      .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr),
      .dram_wdata(dram_wdata), .dram_wmask(dram_wmask), .dram_ack(dram_ack),
      .sys_bus_we(sys_bus_we), .sys_bus_addr(sys_bus_addr),
      .sys_bus_din(sys_bus_din), .sys_bus_wmask(sys_bus_wmask),
      .memp_busy(memp_busy), .is_dram_MEMP(is_dram_MEMP), .pc_MEMP(pc_MEMP),
      .rf_wr_sel_MEMP(rf_wr_sel_MEMP), .rf_wr_en_MEMP(rf_wr_en_MEMP),
      .alu_result_MEMP(alu_result_MEMP),
`ifdef MEMP_MISALIGN_TRAP_EN
      .misalign_MEMP(misalign_MEMP),
`endif
      .rd_MEMP(rd_MEMP)
   );

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      logic        rd;
      logic        wr;
      logic [1:0]  size;
      logic        valid;
      logic        flush;
      logic        wen;
      int          dly;        // extra REQ cycles before ack
      logic        exp_dram;
      logic        exp_sys;    // system-bus access (load or store)
      logic        exp_sys_we;
      logic [7:0]  exp_mask;
      logic [63:0] exp_wdata;
      logic        exp_wen;
      logic        exp_mis;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_EX = 1'b0; mem_rd_EX = 1'b0; mem_wr_EX = 1'b0;
      flush = 1'b0; rf_wr_en_EX = 1'b0;
   endtask

   function automatic vec_t mkv(
      input logic [63:0] addr, input logic [63:0] data, input logic rd, input logic wr,
      input logic [1:0] size, input logic valid, input logic fl, input logic wen, input int dly,
      input logic e_dram, input logic e_sys, input logic e_we, input logic [7:0] e_mask,
      input logic [63:0] e_wdata, input logic e_wen, input logic e_mis);
      vec_t v;
      v.addr = addr; v.data = data; v.rd = rd; v.wr = wr; v.size = size;
      v.valid = valid; v.flush = fl; v.wen = wen; v.dly = dly;
      v.exp_dram = e_dram; v.exp_sys = e_sys; v.exp_sys_we = e_we;
      v.exp_mask = e_mask; v.exp_wdata = e_wdata; v.exp_wen = e_wen; v.exp_mis = e_mis;
      return v;
   endfunction

   // Reference model: it works with byte counts and byte offsets rather than
   // with the encodings of the mask and the store data.
   function automatic vec_t model(input vec_t v);
      vec_t        r;
      int          n;
      int          off;
      logic [15:0] m;
      logic        in_dram, is_mem, live, mis;
      r = v;
      n = 1 << v.size;
      off = (int'(v.addr[2:0]) / n) * n;
      m = ((16'd1 << n) - 16'd1) << off;
      r.exp_mask = m[7:0];
      for (int i = 0; i < 8; i++)
         r.exp_wdata[i*8 +: 8] = v.data[(i % n)*8 +: 8];
      in_dram = (v.addr >= BASE) && ((v.addr - BASE) < SIZE);
      is_mem  = v.rd | v.wr;
      live    = v.valid && !v.flush;
`ifdef MEMP_MISALIGN_TRAP_EN
      mis = live && is_mem && ((int'(v.addr[2:0]) % n) != 0);
`else
      mis = 1'b0;
`endif
      r.exp_mis    = mis;
      r.exp_dram   = live && is_mem && !mis && in_dram;
      r.exp_sys    = live && is_mem && !mis && !in_dram;
      r.exp_sys_we = r.exp_sys && v.wr;
      r.exp_wen    = v.wen && live && !mis;
      return r;
   endfunction

   // Applies one instruction from IDLE, checks the capture, completes any
   // DRAM handshake and then inserts one bubble cycle.
   task automatic apply(input vec_t v, input string tag);
      logic [63:0] pc;
      logic [4:0]  rdn;
      logic [1:0]  sel;
      pc  = {$urandom, $urandom};
      rdn = 5'($urandom);
      sel = 2'($urandom);
      pc_EX = pc; rd_EX = rdn; rf_wr_sel_EX = sel;
      alu_result_EX = v.addr; store_data_EX = v.data;
      mem_rd_EX = v.rd; mem_wr_EX = v.wr; mem_size_EX = v.size;
      valid_EX = v.valid; flush = v.flush; rf_wr_en_EX = v.wen;
      dram_ack = 1'b0;
      tick();
      chk({tag, ".pc_MEMP"}, pc_MEMP, pc);
      chk({tag, ".alu_result_MEMP"}, alu_result_MEMP, v.addr);
      chk({tag, ".rd_MEMP"}, 64'(rd_MEMP), 64'(rdn));
      chk({tag, ".rf_wr_sel_MEMP"}, 64'(rf_wr_sel_MEMP), 64'(sel));
      chk({tag, ".rf_wr_en_MEMP"}, 64'(rf_wr_en_MEMP), 64'(v.exp_wen));
      chk({tag, ".is_dram_MEMP"}, 64'(is_dram_MEMP), 64'(v.exp_dram));
      chk({tag, ".dram_req"}, 64'(dram_req), 64'(v.exp_dram));
      chk({tag, ".memp_busy"}, 64'(memp_busy), 64'(v.exp_dram));
      chk({tag, ".sys_bus_we"}, 64'(sys_bus_we), 64'(v.exp_sys_we));
`ifdef MEMP_MISALIGN_TRAP_EN
      chk({tag, ".misalign_MEMP"}, 64'(misalign_MEMP), 64'(v.exp_mis));
`endif
      if (v.exp_dram) begin
         chk({tag, ".dram_we"}, 64'(dram_we), 64'(v.wr));
         chk({tag, ".dram_addr"}, dram_addr, {v.addr[63:3], 3'b000});
         chk({tag, ".dram_wmask"}, 64'(dram_wmask), 64'(v.exp_mask));
         if (v.wr) chk({tag, ".dram_wdata"}, dram_wdata, v.exp_wdata);
         for (int k = 0; k <= v.dly; k++) begin
            dram_ack = (k == v.dly);
            tick();
            dram_ack = 1'b0;
            if (k < v.dly) begin
               chk({tag, ".hold_req"}, 64'(dram_req), 64'd1);
               chk({tag, ".hold_busy"}, 64'(memp_busy), 64'd1);
               chk({tag, ".hold_mask"}, 64'(dram_wmask), 64'(v.exp_mask));
               if (v.wr) chk({tag, ".hold_wdata"}, dram_wdata, v.exp_wdata);
            end else begin
               chk({tag, ".ack_req"}, 64'(dram_req), 64'd0);
               chk({tag, ".ack_busy"}, 64'(memp_busy), 64'd0);
            end
         end
      end
      if (v.exp_sys) begin
         chk({tag, ".sys_bus_addr"}, sys_bus_addr, v.addr);
         chk({tag, ".sys_bus_wmask"}, 64'(sys_bus_wmask), 64'(v.exp_mask));
         if (v.wr) chk({tag, ".sys_bus_din"}, sys_bus_din, v.exp_wdata);
      end
      idle_inputs();
      tick();
      chk({tag, ".post_sys_we"}, 64'(sys_bus_we), 64'd0);
      chk({tag, ".post_req"}, 64'(dram_req), 64'd0);
      chk({tag, ".post_busy"}, 64'(memp_busy), 64'd0);
      $display("txn %s addr=%h rd=%0d wr=%0d size=%0d dram=%0d sys_we=%0d errors=%0d",
               tag, v.addr, v.rd, v.wr, v.size, v.exp_dram, v.exp_sys_we, errors);
   endtask

   vec_t tbl[12];

   initial begin
      logic [63:0] pc_a, pc_b, pc_c, pc_d;
      vec_t        v;

      // Each table entry lists addr, data, rd, wr, size, valid, flush,
      // wen and dly, followed by the expected dram, sys, sys_we, mask,
      // wdata, wen and mis.
      tbl[0]  = mkv(64'h8000_0004, 64'h1122_3344, 0, 1, 2'b10, 1, 0, 0, 2,
                    1, 0, 0, 8'hF0, 64'h11223344_11223344, 0, 0);
      tbl[1]  = mkv(64'h8000_0010, 64'h0, 1, 0, 2'b11, 1, 0, 1, 0,
                    1, 0, 0, 8'hFF, 64'h0, 1, 0);
      tbl[2]  = mkv(64'h1000_0003, 64'hAB, 0, 1, 2'b00, 1, 0, 0, 0,
                    0, 1, 1, 8'h08, 64'hABABABAB_ABABABAB, 0, 0);
`ifdef MEMP_MISALIGN_TRAP_EN
      tbl[3]  = mkv(64'h8000_0001, 64'h0, 1, 0, 2'b01, 1, 0, 1, 1,
                    0, 0, 0, 8'h03, 64'h0, 0, 1);
      tbl[10] = mkv(64'h1000_0006, 64'hDEAD_BEEF, 0, 1, 2'b10, 1, 0, 0, 0,
                    0, 0, 0, 8'hF0, 64'hDEADBEEF_DEADBEEF, 0, 1);
`else
      tbl[3]  = mkv(64'h8000_0001, 64'h0, 1, 0, 2'b01, 1, 0, 1, 1,
                    1, 0, 0, 8'h03, 64'h0, 1, 0);
      tbl[10] = mkv(64'h1000_0006, 64'hDEAD_BEEF, 0, 1, 2'b10, 1, 0, 0, 0,
                    0, 1, 1, 8'hF0, 64'hDEADBEEF_DEADBEEF, 0, 0);
`endif
      tbl[4]  = mkv(64'h8000_0000, 64'h0, 0, 0, 2'b11, 1, 0, 1, 0,
                    0, 0, 0, 8'hFF, 64'h0, 1, 0);
      tbl[5]  = mkv(64'h0000_1234, 64'h0, 0, 0, 2'b00, 1, 1, 1, 0,
                    0, 0, 0, 8'h00, 64'h0, 0, 0);
      tbl[6]  = mkv(64'h8800_0000, 64'h0, 1, 0, 2'b10, 1, 0, 1, 0,
                    0, 1, 0, 8'h0F, 64'h0, 1, 0);
      tbl[7]  = mkv(64'h7FFF_FFFF, 64'h5A, 0, 1, 2'b00, 1, 0, 0, 0,
                    0, 1, 1, 8'h80, 64'h5A5A5A5A_5A5A5A5A, 0, 0);
      tbl[8]  = mkv(64'h87FF_FFFE, 64'hBEEF, 0, 1, 2'b01, 1, 0, 0, 3,
                    1, 0, 0, 8'hC0, 64'hBEEFBEEF_BEEFBEEF, 0, 0);
      tbl[9]  = mkv(64'h8000_0100, 64'h77, 0, 1, 2'b11, 0, 0, 1, 0,
                    0, 0, 0, 8'hFF, 64'h77, 0, 0);
      tbl[11] = mkv(64'h8000_0008, 64'h01234567_89ABCDEF, 0, 1, 2'b11, 1, 0, 0, 1,
                    1, 0, 0, 8'hFF, 64'h01234567_89ABCDEF, 0, 0);

      // The bench holds reset low for the first cycles; every output must be 0.
      repeat (2) @(posedge clk);
      #1;
      chk("rst.dram_req", 64'(dram_req), 64'd0);
      chk("rst.sys_bus_we", 64'(sys_bus_we), 64'd0);
      chk("rst.memp_busy", 64'(memp_busy), 64'd0);
      chk("rst.pc_MEMP", pc_MEMP, 64'd0);
      chk("rst.dram_wmask", 64'(dram_wmask), 64'd0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("tbl%0d", i));

      // Randomized instructions checked against the reference model
      for (int i = 0; i < 60; i++) begin
         v = mkv(0, {$urandom, $urandom}, 0, 0, 2'($urandom), 1, 0, 1'($urandom),
                 $urandom_range(0, 3), 0, 0, 0, 0, 0, 0, 0);
         case ($urandom_range(0, 3))
            0: v.addr = BASE + 64'($urandom_range(0, 32'h07FF_FFFF));
            1: v.addr = {$urandom, $urandom};
            2: case ($urandom_range(0, 3))
                  0: v.addr = BASE - 64'($urandom_range(1, 8));
                  1: v.addr = BASE + 64'($urandom_range(0, 7));
                  2: v.addr = BASE + SIZE - 64'($urandom_range(1, 8));
                  default: v.addr = BASE + SIZE + 64'($urandom_range(0, 7));
               endcase
            default: v.addr = 64'h1000_0000 + 64'($urandom_range(0, 255));
         endcase
         case ($urandom_range(0, 2))
            0: begin v.rd = 1'b0; v.wr = 1'b0; end
            1: begin v.rd = 1'b1; v.wr = 1'b0; end
            default: begin v.rd = 1'b0; v.wr = 1'b1; end
         endcase
         v.valid = ($urandom_range(0, 7) != 0);
         v.flush = ($urandom_range(0, 7) == 0);
         apply(model(v), $sformatf("rnd%0d", i));
      end

      // stall held 4 cycles, then capture on release with flush
      pc_a = 64'hA000; pc_b = 64'hB000;
      pc_EX = pc_a; alu_result_EX = 64'h11; valid_EX = 1'b1; rf_wr_en_EX = 1'b1;
      tick();
      chk("stall.pre_pc", pc_MEMP, pc_a);
      stall = 1'b1; pc_EX = pc_b; alu_result_EX = 64'h22;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("stall.hold_pc", pc_MEMP, pc_a);
         chk("stall.hold_alu", alu_result_MEMP, 64'h11);
      end
      stall = 1'b0; flush = 1'b1;
      tick();
      chk("stall.release_pc", pc_MEMP, pc_b);
      chk("stall.flush_wen", 64'(rf_wr_en_MEMP), 64'd0);
      idle_inputs();
      tick();
      $display("txn stall_flush errors=%0d", errors);

      // stall arrives during REQ: the handshake completes and no capture follows
      pc_c = 64'hC000; pc_d = 64'hD000;
      pc_EX = pc_c; alu_result_EX = 64'h8000_0020; mem_rd_EX = 1'b1;
      mem_size_EX = 2'b11; valid_EX = 1'b1; rf_wr_en_EX = 1'b1;
      tick();
      chk("reqstall.req", 64'(dram_req), 64'd1);
      stall = 1'b1; mem_rd_EX = 1'b0; pc_EX = pc_d; alu_result_EX = 64'h5;
      dram_ack = 1'b1;
      tick();
      dram_ack = 1'b0;
      chk("reqstall.ack_req", 64'(dram_req), 64'd0);
      chk("reqstall.ack_busy", 64'(memp_busy), 64'd0);
      tick();
      chk("reqstall.no_capture", pc_MEMP, pc_c);
      stall = 1'b0;
      tick();
      chk("reqstall.capture", pc_MEMP, pc_d);
      chk("reqstall.no_req", 64'(dram_req), 64'd0);
      idle_inputs();
      tick();
      $display("txn stall_in_req errors=%0d", errors);

      // reset asserted in the middle of REQ
      pc_EX = 64'hE000; alu_result_EX = 64'h8000_0040; mem_wr_EX = 1'b1;
      mem_size_EX = 2'b10; valid_EX = 1'b1; rf_wr_en_EX = 1'b1; rd_EX = 5'd9;
      tick();
      chk("midrst.req_before", 64'(dram_req), 64'd1);
      reset = 1'b0;
      #1;
      chk("midrst.dram_req", 64'(dram_req), 64'd0);
      chk("midrst.memp_busy", 64'(memp_busy), 64'd0);
      chk("midrst.pc_MEMP", pc_MEMP, 64'd0);
      chk("midrst.alu_result_MEMP", alu_result_MEMP, 64'd0);
      chk("midrst.rd_MEMP", 64'(rd_MEMP), 64'd0);
      chk("midrst.is_dram_MEMP", 64'(is_dram_MEMP), 64'd0);
      chk("midrst.dram_wmask", 64'(dram_wmask), 64'd0);
      idle_inputs();
      tick();
      reset = 1'b1;
      tick();
      chk("midrst.idle_busy", 64'(memp_busy), 64'd0);
      $display("txn reset_mid_req errors=%0d", errors);
      apply(tbl[1], "post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
